// File: rtl/bram_resp_fifo.sv
// Read-response FIFO with issue credit for the BRAM controller.
// Optional same-cycle bypass when empty: define BRAM_RESP_BYPASS_EN.
module bram_resp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int CW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_in_valid,
    input  logic [DATA_W-1:0] fifo_in_data,
    input  logic              rd_issue,
    output logic              issue_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     outstanding,
    output logic              overflow
);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_C1 = (CW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          overflow_q, overflow_d;

    logic          mem_pop;
    logic          space;
    logic          bypass_take;
    logic          push;
    logic          issue_ok;
    logic          ret;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mem_pop     = 1'b0;
        space       = 1'b0;
        bypass_take = 1'b0;
        push        = 1'b0;
        issue_ready = 1'b0;
        issue_ok    = 1'b0;
        ret         = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        outst_d     = outst_q;
        overflow_d  = overflow_q;

        mem_pop = (count_q != '0) && out_ready;
        space   = (count_q < DEPTH_C) || mem_pop;
`ifdef BRAM_RESP_BYPASS_EN
        // An empty FIFO hands the word straight to a ready consumer; nothing is stored.
        bypass_take = (count_q == '0) && fifo_in_valid && out_ready;
`endif
        push = fifo_in_valid && space && !bypass_take;

        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (mem_pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, mem_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (fifo_in_valid && !space)
            overflow_d = 1'b1;

        // Credit covers both stored words and words still in the BRAM pipeline.
        issue_ready = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C1;
        issue_ok    = rd_issue && issue_ready;
        ret         = fifo_in_valid && (outst_q != '0);

        unique case ({issue_ok, ret})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates visibility, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= fifo_in_data;
    end

`ifdef BRAM_RESP_BYPASS_EN
    assign out_valid = (count_q != '0) || fifo_in_valid;
    assign out_data  = (count_q == '0) ? fifo_in_data : mem_q[rd_ptr_q[AW-1:0]];
`else
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
`endif

    assign count       = count_q;
    assign outstanding = outst_q;
    assign overflow    = overflow_q;

    // Credit accounting guarantees the FIFO never holds more than DEPTH words in total.
    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, count_q} + {1'b0, outst_q}) <= DEPTH_C1);
    a_overflow_sticky : assert property (@(posedge clk) disable iff (!rst_n)
        overflow_q |=> overflow_q);

endmodule

// File: tb/tb_bram_resp_fifo.sv
// Scoreboard bench for bram_resp_fifo; expected words are queued on push and compared on pop.
module tb_bram_resp_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int CW     = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fifo_in_valid;
    logic [DATA_W-1:0] fifo_in_data;
    logic              rd_issue;
    logic              issue_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    bram_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_data  (fifo_in_data),
        .rd_issue      (rd_issue),
        .issue_ready   (issue_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .count         (count),
        .outstanding   (outstanding),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fifo_in_valid = 1'b0;
        fifo_in_data  = '0;
        rd_issue      = 1'b0;
        out_ready     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_issue_credit();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_issue = 1'b1;
            step();
        end
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL issue_outstanding got %0d exp 16", outstanding); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL issue_ready_full got %b exp 0", issue_ready); end
        step();
        rd_issue = 1'b0;
        checks++; if (outstanding !== 5'd16) begin errors++; $display("FAIL issue_17th_ignored got %0d exp 16", outstanding); end
        for (int i = 0; i < DEPTH; i++) begin
            fifo_in_valid = 1'b1;
            fifo_in_data  = 32'h100 + i;
            sb_q.push_back(32'h100 + i);
            step();
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL return_issue_ready[%0d] got %b exp 0", i, issue_ready); end
        end
        fifo_in_valid = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL return_count got %0d exp 16", count); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL return_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_push_pop_full();
        logic [DATA_W-1:0] exp;
        out_ready     = 1'b1;
        fifo_in_valid = 1'b1;
        fifo_in_data  = 32'hBEEF;
        #1;
        exp = sb_q.pop_front();
        checks++; if (out_data !== exp) begin errors++; $display("FAIL pp_head got %h exp %h", out_data, exp); end
        sb_q.push_back(32'hBEEF);
        step();
        idle_inputs();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL pp_count got %0d exp 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow got %b exp 0", overflow); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL pp_issue_ready got %b exp 0", issue_ready); end
        // Drain everything, including 0xBEEF as the last word.
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            exp = sb_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_data !== exp) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_data, exp); end
            step();
            if (i == 0) begin
                checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL drain_issue_ready got %b exp 1", issue_ready); end
            end
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b exp 0", out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_empty_count got %0d exp 0", count); end
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_in_valid = 1'b1;
            fifo_in_data  = 32'h200 + i;
            sb_q.push_back(32'h200 + i);
            step();
        end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL unsol_outstanding got %0d exp 0", outstanding); end
        fifo_in_data = 32'hDEAD;
        step();
        fifo_in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
        checks++; if (out_data !== 32'h200) begin errors++; $display("FAIL ovf_head got %h exp 00000200", out_data); end
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = sb_q.pop_front();
            checks++; if (out_data !== exp) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, out_data, exp); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_single_word();
        out_ready     = 1'b1;
        fifo_in_valid = 1'b1;
        fifo_in_data  = 32'hA5A5A5A5;
        #1;
`ifdef BRAM_RESP_BYPASS_EN
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_data got %h exp a5a5a5a5", out_data); end
        step();
        fifo_in_valid = 1'b0;
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL byp_count got %0d exp 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL byp_after_valid got %b exp 0", out_valid); end
`else
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_same_cycle got %b exp 0", out_valid); end
        step();
        fifo_in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL single_data got %h exp a5a5a5a5", out_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
        step();
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_popped got %0d exp 0", count); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            fifo_in_valid = 1'b1;
            fifo_in_data  = 32'h300 + i;
            rd_issue      = (i < 2);
            step();
        end
        idle_inputs();
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL areset_pre_count got %0d exp 5", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
        checks++; if (outstanding !== 5'd0) begin errors++; $display("FAIL areset_outstanding got %0d exp 0", outstanding); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b exp 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow got %b exp 0", overflow); end
        step();
        rst_n = 1'b1;
        step();
        sb_q.delete();
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        logic vin, rdy, pop, byp, push, exp_valid;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 120; i++) begin
            vin = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            d   = $urandom;
            fifo_in_valid = vin;
            fifo_in_data  = d;
            out_ready     = rdy;
            #1;
            byp = 1'b0;
`ifdef BRAM_RESP_BYPASS_EN
            byp = (cnt == 0) && vin && rdy;
            exp_valid = (cnt != 0) || vin;
`else
            exp_valid = (cnt != 0);
`endif
            checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, out_valid, exp_valid); end
            if (cnt != 0) begin
                checks++; if (out_data !== sb_q[0]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, out_data, sb_q[0]); end
            end else if (byp) begin
                checks++; if (out_data !== d) begin errors++; $display("FAIL b2b_bypass[%0d] got %h exp %h", i, out_data, d); end
            end
            pop  = (cnt != 0) && rdy;
            push = vin && !byp && ((cnt < DEPTH) || pop);
            if (pop)
                void'(sb_q.pop_front());
            if (push)
                sb_q.push_back(d);
            cnt = cnt + int'(push) - int'(pop);
            step();
        end
        idle_inputs();
        checks++; if (count !== CW'(cnt)) begin errors++; $display("FAIL b2b_count got %0d exp %0d", count, cnt); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_issue_credit();
        test_push_pop_full();
        test_overflow();
        test_single_word();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/bram_resp_fifo.md
Name: bram_resp_fifo

Overview:
- Read-response buffer on the CPU side of the user-project BRAM controller.
- Captures the controller's fixed-latency read data (fifo_in_valid/Do), which has no backpressure, into a circular FIFO and presents it to the CPU/Wishbone side with a valid/ready handshake.
- Tracks reads already issued to the BRAM but not yet returned, and grants the arbiter permission to issue a new read only if FIFO space is reserved for its response, so a response is never lost.

Parameters:
- DATA_W, 32, width of the response data word.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, log2(DEPTH); pointer index width.
- CW, 5, AW+1; width of the count and outstanding counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_in_valid  in  1  BRAM controller read-data strobe; one word per cycle when high.
- fifo_in_data  in  DATA_W  BRAM controller Do; sampled when fifo_in_valid is high.
- rd_issue  in  1  arbiter is issuing a BRAM read this cycle.
- issue_ready  out  1  a new read may be issued; response space is reserved.
- out_valid  out  1  out_data holds a valid response.
- out_data  out  DATA_W  head-of-FIFO response word.
- out_ready  in  1  consumer accepts out_data this cycle.
- count  out  CW  words currently stored.
- outstanding  out  CW  reads issued but not yet returned.
- overflow  out  1  sticky error flag: a push was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, outstanding=0, overflow=0. Therefore out_valid=0 and issue_ready=1. Memory contents are don't-care. Reset mid-operation discards all stored and in-flight responses. Responses arriving after reset release are treated as unsolicited pushes (see below).
- Storage: DEPTH x DATA_W array. Pointers are AW+1 bits, and the extra bit distinguishes full from empty. Pointers wrap modulo 2*DEPTH; the index uses the low AW bits.
- push = fifo_in_valid && (count<DEPTH || pop).
- pop = out_valid && out_ready.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full boundary: fifo_in_valid at count==DEPTH with no pop means the word is dropped, overflow is set to 1 and held until reset, and the pointers do not change. Push and pop together at full both take effect and count stays at DEPTH.
- Empty boundary: pop cannot occur because out_valid=0. A push into an empty FIFO sets out_valid from the next cycle (1-cycle latency, no bypass unless the option below is enabled).
- Output: show-ahead. out_data = mem[rd_ptr[AW-1:0]] and out_valid = (count!=0), both driven from registered state only. out_data and out_valid stay stable while out_valid && !out_ready.
- Issue credit:
  - issue_ready = (count + outstanding) < DEPTH, computed from registers with CW+1-bit addition.
  - issue_ok = rd_issue && issue_ready.
  - rd_issue while issue_ready=0 is ignored (the arbiter must not issue).
  - ret = fifo_in_valid && (outstanding!=0).
  - outstanding update: +1 on issue_ok only, -1 on ret only, unchanged on both or neither.
  - fifo_in_valid with outstanding==0 (controller pre-store writeback) is still pushed if space allows; outstanding saturates at 0.
- Invariant when issues respect issue_ready: count+outstanding <= DEPTH, so overflow can only come from unsolicited pushes.
- Latency is independent of BRAM latency. The controller's 10-cycle latency only sets how long outstanding stays non-zero. Back-to-back issues up to DEPTH are supported.

Optional Feature:
- Macro: BRAM_RESP_BYPASS_EN.
- Defined: when count==0 and fifo_in_valid=1, out_valid=1 and out_data=fifo_in_data combinationally in the same cycle. If out_ready=1 that cycle, the word is consumed without being written, and pointers and count are unchanged. If out_ready=0, the word is stored normally. outstanding decrements as for any return.
- Undefined: no combinational path from fifo_in_* to out_*, and first-word latency is 1 cycle.

Test Plan:
- Reset, then idle: count=0, outstanding=0, out_valid=0, issue_ready=1, overflow=0. Assert rst_n low mid-stream with count=5 -> all counters 0 immediately, without waiting for a clock edge.
- Issue 16 reads back-to-back with out_ready=0 -> outstanding reaches 16 and issue_ready=0 after the 16th. A 17th rd_issue is ignored. Return 16 words 0x100..0x10F -> count=16, outstanding=0, issue_ready stays 0.
- From the full state, hold out_ready=1 -> out_data sequence 0x100..0x10F, one per cycle. issue_ready rises in the cycle after the first pop. out_valid falls after the 16th pop.
- Full FIFO, out_ready=0, inject unsolicited fifo_in_valid with 0xDEAD -> overflow=1 and stays 1. count=16 and head=0x100 are unchanged.
- Full FIFO, out_ready=1 and fifo_in_valid=1 (0xBEEF) in the same cycle -> count stays 16. 0xBEEF appears as the 16th word after the existing data drains. overflow=0.
- Single word 0xA5A5A5A5 pushed into an empty FIFO with out_ready=1 -> without macro: out_valid high in the next cycle. With BRAM_RESP_BYPASS_EN: out_valid and data in the same cycle, and count stays 0.
